// File: rtl/squarer_4bit_if.sv
// Operand/result bundle for squarer_4bit: operand in, registered square and garbage buses out.
interface squarer_4bit_if;
  logic [3:0]  a;
  logic [7:0]  Y;
  logic [31:0] garbage_pp;
  logic [31:0] garbage_sum;

  modport master (output a, input Y, garbage_pp, garbage_sum);
  modport slave  (input a, output Y, garbage_pp, garbage_sum);
endinterface

// File: rtl/squarer_4bit.sv
// Unsigned 4-bit squarer built from Peres-gate cross products and a weighted adder.
// Define SQUARER_GARBAGE_EN to export registered gate garbage; otherwise both garbage buses tie to 0.
module squarer_4bit (
  input  logic          clk,
  input  logic          rst,
  squarer_4bit_if.slave bus
);

  localparam int unsigned AW = 4;
  localparam int unsigned YW = 8;
  localparam int unsigned GW = 32;
  localparam int unsigned NP = 6;

  // Peres gate with C=0: R = A&B, Q = A^B (the P output is just A and goes unused)
  function automatic logic peres_r(input logic pa, input logic pb, input logic pc);
    return (pa & pb) ^ pc;
  endfunction

  logic [AW-1:0] a_c;
  logic [NP-1:0] pp_r_c;
  logic [YW-1:0] d_c;
  logic [YW-1:0] p_c;
  logic [YW-1:0] y_c;
  logic [YW-1:0] y_q;

  assign a_c = bus.a;

  // Cross products in pair order 01,02,03,12,13,23
  always_comb begin
    pp_r_c    = '0;
    pp_r_c[0] = peres_r(a_c[0], a_c[1], 1'b0);
    pp_r_c[1] = peres_r(a_c[0], a_c[2], 1'b0);
    pp_r_c[2] = peres_r(a_c[0], a_c[3], 1'b0);
    pp_r_c[3] = peres_r(a_c[1], a_c[2], 1'b0);
    pp_r_c[4] = peres_r(a_c[1], a_c[3], 1'b0);
    pp_r_c[5] = peres_r(a_c[2], a_c[3], 1'b0);
  end

  // Diagonal terms at bit 2i; p_ij weighted at bit i+j+1
  always_comb begin
    d_c = {1'b0, a_c[3], 1'b0, a_c[2], 1'b0, a_c[1], 1'b0, a_c[0]};
    p_c = (YW'(pp_r_c[0]) << 2) + (YW'(pp_r_c[1]) << 3)
        + (YW'(pp_r_c[2]) << 4) + (YW'(pp_r_c[3]) << 4)
        + (YW'(pp_r_c[4]) << 5) + (YW'(pp_r_c[5]) << 6);
    y_c = d_c + p_c;
  end

  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_c;
  end

  assign bus.Y = y_q;

`ifdef SQUARER_GARBAGE_EN
  function automatic logic peres_q(input logic pa, input logic pb);
    return pa ^ pb;
  endfunction

  logic [NP-1:0] pp_q_c;
  logic [YW-1:0] carry_c;
  logic [GW-1:0] gpp_q;
  logic [GW-1:0] gsum_q;

  always_comb begin
    pp_q_c    = '0;
    pp_q_c[0] = peres_q(a_c[0], a_c[1]);
    pp_q_c[1] = peres_q(a_c[0], a_c[2]);
    pp_q_c[2] = peres_q(a_c[0], a_c[3]);
    pp_q_c[3] = peres_q(a_c[1], a_c[2]);
    pp_q_c[4] = peres_q(a_c[1], a_c[3]);
    pp_q_c[5] = peres_q(a_c[2], a_c[3]);
  end

  // Carry-in vector of the D+P adder
  assign carry_c = d_c ^ p_c ^ y_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      gpp_q  <= '0;
      gsum_q <= '0;
    end else begin
      gpp_q  <= GW'(pp_q_c);
      gsum_q <= GW'(carry_c);
    end
  end

  assign bus.garbage_pp  = gpp_q;
  assign bus.garbage_sum = gsum_q;
`else
  assign bus.garbage_pp  = GW'(0);
  assign bus.garbage_sum = GW'(0);
`endif

endmodule

// File: tb/tb_squarer_4bit.sv
// Scoreboard bench for squarer_4bit: expected results queued on drive, checked one edge later.
module tb_squarer_4bit;

  typedef struct packed {
    logic [3:0]  a;
    logic [7:0]  y;
    logic [31:0] gpp;
    logic [31:0] gsum;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  exp_t sb_q[$];

  squarer_4bit_if bus ();

  squarer_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] av, input logic r);
    exp_t       e;
    logic [7:0] d;
    logic [7:0] p;
    int         k;
    e   = '0;
    e.a = av;
    if (!r) begin
      e.y = 8'(int'(av) * int'(av));
      d   = '0;
      for (int i = 0; i < 4; i++) d[2*i] = av[i];
      p   = e.y - d;
`ifdef SQUARER_GARBAGE_EN
      k = 0;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++) begin
          e.gpp[k] = av[i] ^ av[j];
          k++;
        end
      e.gsum = 32'(d ^ p ^ e.y);
`else
      k = 0;
      if (p == 8'hFF) k = 1;
`endif
    end
    return e;
  endfunction

  // Drive one operand, queue its expectation, then compare after the edge
  task automatic apply(input logic [3:0] av, input logic r);
    exp_t e;
    bus.a = av;
    rst   = r;
    sb_q.push_back(model(av, r));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("Y a=%0d rst=%0b", e.a, r), 32'(bus.Y), 32'(e.y));
      check($sformatf("gpp a=%0d rst=%0b", e.a, r), bus.garbage_pp, e.gpp);
      check($sformatf("gsum a=%0d rst=%0b", e.a, r), bus.garbage_sum, e.gsum);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    bus.a  = 4'hF;

    apply(4'hF, 1'b1);
    apply(4'hF, 1'b1);
    apply(4'hF, 1'b0);

    for (int i = 0; i < 16; i++) apply(4'(i), 1'b0);

    apply(4'd3, 1'b0);
`ifdef SQUARER_GARBAGE_EN
    check("spot gpp a=3", bus.garbage_pp, 32'h1E);
    check("spot gsum a=3", bus.garbage_sum, 32'h08);
`endif
    check("spot Y a=3", 32'(bus.Y), 32'd9);
    apply(4'd15, 1'b0);
    check("spot Y a=15", 32'(bus.Y), 32'hE1);
`ifdef SQUARER_GARBAGE_EN
    check("spot gsum a=15", bus.garbage_sum, 32'h38);
`endif
    apply(4'd5, 1'b0);
    check("spot Y a=5", 32'(bus.Y), 32'd25);
    apply(4'd0, 1'b0);

    apply(4'd15, 1'b0);
    apply(4'd1, 1'b0);
    apply(4'd15, 1'b0);
    apply(4'd1, 1'b1);
    apply(4'd1, 1'b0);

    for (int i = 0; i < 40; i++) apply(4'($urandom_range(15, 0)), ($urandom_range(9, 0) == 0));
    apply(4'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
